// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Slow data-memory responder for the core's load/store port.
//               Accepts one request at a time over valid/ready, holds it for
//               WAIT_CYCLES wait states, performs a sized byte-lane access
//               into a word-organised RAM and returns the result over a
//               second valid/ready handshake.
//               Optional feature macro: MISALIGN_TRAP_EN (misaligned halves
//               and words are suppressed and flagged on resp_err).
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         c_AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [3:0]      r_cnt;

    logic            r_write;
    logic [c_AW+1:0] r_addr;
    logic [31:0]     r_wdata;
    logic [1:0]      r_size;
    logic            r_unsigned;

    logic            r_resp_valid;
    logic [31:0]     r_resp_rdata;

    logic [31:0]     r_mem [DEPTH_WORDS];

    logic            w_accept;
    logic            w_do_access;
    logic            w_acc_write;
    logic [c_AW+1:0] w_acc_addr;
    logic [31:0]     w_acc_wdata;
    logic [1:0]      w_acc_size;
    logic            w_acc_unsigned;
    logic [c_AW-1:0] w_idx;
    logic [31:0]     w_rd_word;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [3:0]      w_be;
    logic [31:0]     w_wword;
    logic [31:0]     w_load;
    logic [31:0]     w_rdata;

    // Address bits above the RAM window only alias, they never select.
    logic            w_unused_addr;
    assign w_unused_addr = ^req_addr[31:c_AW+2];

    assign req_ready  = (r_state == c_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;

    assign w_accept = (r_state == c_IDLE) && req_valid;

    // With zero wait states the access happens on the handshake edge itself,
    // so the live request fields are used instead of the latched copy.
    assign w_do_access = (WAIT_CYCLES == 0) ? w_accept
                                            : ((r_state == c_WAIT) && (r_cnt == 4'd0));

    assign w_acc_write    = (r_state == c_IDLE) ? req_write          : r_write;
    assign w_acc_addr     = (r_state == c_IDLE) ? req_addr[c_AW+1:0] : r_addr;
    assign w_acc_wdata    = (r_state == c_IDLE) ? req_wdata          : r_wdata;
    assign w_acc_size     = (r_state == c_IDLE) ? req_size           : r_size;
    assign w_acc_unsigned = (r_state == c_IDLE) ? req_unsigned       : r_unsigned;

    assign w_idx     = w_acc_addr[c_AW+1:2];
    assign w_rd_word = r_mem[w_idx];
    assign w_byte    = w_rd_word[8*w_acc_addr[1:0] +: 8];
    assign w_half    = w_acc_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];

`ifdef MISALIGN_TRAP_EN
    logic w_misalign;
    logic r_resp_err;
    assign w_misalign = ((w_acc_size == 2'b01) && w_acc_addr[0]) ||
                        (w_acc_size[1] && (w_acc_addr[1:0] != 2'b00));
    assign resp_err   = r_resp_err;
`else
    assign resp_err   = 1'b0;
`endif

    // Byte-lane enables, replicated store data and extended load data.
    always_comb begin
        w_be    = 4'b0000;
        w_wword = w_acc_wdata;
        w_load  = w_rd_word;
        case (w_acc_size)
            2'b00: begin
                w_be    = 4'b0001 << w_acc_addr[1:0];
                w_wword = {4{w_acc_wdata[7:0]}};
                w_load  = w_acc_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            2'b01: begin
                w_be    = w_acc_addr[1] ? 4'b1100 : 4'b0011;
                w_wword = {2{w_acc_wdata[15:0]}};
                w_load  = w_acc_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            end
            default: begin
                w_be    = 4'b1111;
                w_wword = w_acc_wdata;
                w_load  = w_rd_word;
            end
        endcase
`ifdef MISALIGN_TRAP_EN
        if (w_misalign) begin
            w_be   = 4'b0000;
            w_load = 32'd0;
        end
`endif
        w_rdata = w_acc_write ? 32'd0 : w_load;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = (WAIT_CYCLES == 0) ? c_RESP : c_WAIT;
                end
            end
            c_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = c_RESP;
                end
            end
            c_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Wait-state counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= c_WAIT_INIT;
        end else if ((r_state == c_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Request capture on the handshake edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
        end else if (w_accept) begin
            r_write    <= req_write;
            r_addr     <= req_addr[c_AW+1:0];
            r_wdata    <= req_wdata;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
        end
    end

    // RAM lane writes; a reset on the access edge drops the pending store.
    always_ff @(posedge clk) begin
        if (w_do_access && w_acc_write && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
                end
            end
        end
    end

    // Response registers: loaded on the access edge, cleared when consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
        end else if (w_do_access) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_rdata;
        end else if ((r_state == c_RESP) && resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
        end
    end

`ifdef MISALIGN_TRAP_EN
    // Misalignment flag travels with the response data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_resp_err <= 1'b0;
        end else if (w_do_access) begin
            r_resp_err <= w_misalign;
        end else if ((r_state == c_RESP) && resp_ready) begin
            r_resp_err <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Directed, table-driven bench for data_mem_responder with the
//               default parameters (DEPTH_WORDS=256, WAIT_CYCLES=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks   = 0;
    int failures = 0;

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic u, input logic [31:0] er,
                       input logic ee);
        vec_t v;
        v.w = w; v.addr = a; v.wdata = d; v.size = sz; v.uns = u;
        v.exp_rdata = er; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    // Called at the negedge following the handshake edge.
    task automatic wait_resp(output int lat);
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Starts and ends on a negedge with the responder idle.
    task automatic transact(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] sz, input logic u,
                            output logic [31:0] rd, output logic er, output int lat);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        req_size = sz; req_unsigned = u;
        @(negedge clk);
        req_valid = 1'b0;
        wait_resp(lat);
        rd = resp_rdata;
        er = resp_err;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        seen;
        logic [31:0] exp80;

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0;
        req_wdata = 32'd0; req_size = 2'b00; req_unsigned = 1'b0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset req_ready", {31'd0, req_ready}, 32'd1);
        check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset resp_rdata", resp_rdata, 32'd0);
        check("reset resp_err", {31'd0, resp_err}, 32'd0);

        // w, addr, wdata, size, unsigned, expected rdata, expected err
        add(1'b1, 32'h40,  32'hDEADBEEF, 2'b10, 1'b0, 32'h00000000, 1'b0);
        add(1'b0, 32'h40,  32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0);
        add(1'b1, 32'h44,  32'h11223344, 2'b10, 1'b0, 32'h00000000, 1'b0);
        add(1'b1, 32'h45,  32'h000000A5, 2'b00, 1'b0, 32'h00000000, 1'b0);
        add(1'b0, 32'h44,  32'h0,        2'b10, 1'b0, 32'h1122A544, 1'b0);
        add(1'b0, 32'h45,  32'h0,        2'b00, 1'b0, 32'hFFFFFFA5, 1'b0);
        add(1'b0, 32'h45,  32'h0,        2'b00, 1'b1, 32'h000000A5, 1'b0);
        add(1'b1, 32'h48,  32'h80017FFF, 2'b10, 1'b0, 32'h00000000, 1'b0);
        add(1'b0, 32'h4A,  32'h0,        2'b01, 1'b0, 32'hFFFF8001, 1'b0);
        add(1'b0, 32'h4A,  32'h0,        2'b01, 1'b1, 32'h00008001, 1'b0);
        add(1'b0, 32'h48,  32'h0,        2'b01, 1'b0, 32'h00007FFF, 1'b0);
        add(1'b0, 32'h43,  32'h0,        2'b00, 1'b1, 32'h000000DE, 1'b0);
        add(1'b0, 32'h43,  32'h0,        2'b00, 1'b0, 32'hFFFFFFDE, 1'b0);
        add(1'b1, 32'h4C,  32'h00000000, 2'b10, 1'b0, 32'h00000000, 1'b0);
        add(1'b1, 32'h4E,  32'hFFFFBEEF, 2'b01, 1'b0, 32'h00000000, 1'b0);
        add(1'b0, 32'h4C,  32'h0,        2'b10, 1'b0, 32'hBEEF0000, 1'b0);
        add(1'b1, 32'h400, 32'hCAFEF00D, 2'b10, 1'b0, 32'h00000000, 1'b0);
        add(1'b0, 32'h000, 32'h0,        2'b10, 1'b0, 32'hCAFEF00D, 1'b0);
        add(1'b0, 32'h40,  32'h0,        2'b11, 1'b0, 32'hDEADBEEF, 1'b0);

        foreach (vecs[i]) begin
            transact(vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns,
                     rd, er, lat);
            check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d latency", i), lat, 32'd3);
        end

`ifdef MISALIGN_TRAP_EN
        transact(1'b1, 32'h80, 32'h55AA55AA, 2'b10, 1'b0, rd, er, lat);
        transact(1'b1, 32'h82, 32'h12345678, 2'b10, 1'b0, rd, er, lat);
        check("misalign store err", {31'd0, er}, 32'd1);
        check("misalign store latency", lat, 32'd3);
        transact(1'b0, 32'h80, 32'h0, 2'b10, 1'b0, rd, er, lat);
        check("misalign store no write", rd, 32'h55AA55AA);
        transact(1'b0, 32'h81, 32'h0, 2'b01, 1'b0, rd, er, lat);
        check("misalign load rdata", rd, 32'd0);
        check("misalign load err", {31'd0, er}, 32'd1);
        exp80 = 32'h55AA55AA;
`else
        transact(1'b1, 32'h82, 32'h12345678, 2'b10, 1'b0, rd, er, lat);
        check("unaligned store err", {31'd0, er}, 32'd0);
        transact(1'b0, 32'h80, 32'h0, 2'b10, 1'b0, rd, er, lat);
        check("unaligned word store lands at 0x80", rd, 32'h12345678);
        transact(1'b0, 32'h83, 32'h0, 2'b01, 1'b1, rd, er, lat);
        check("unaligned half load", rd, 32'h00001234);
        exp80 = 32'h12345678;
`endif

        // Reset on the edge where the pending store would be performed.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h80;
        req_wdata = 32'hFFFFFFFF; req_size = 2'b10; req_unsigned = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | resp_valid;
        end
        check("reset-in-wait resp_valid never rises", {31'd0, seen}, 32'd0);
        check("reset-in-wait req_ready", {31'd0, req_ready}, 32'd1);
        transact(1'b0, 32'h80, 32'h0, 2'b10, 1'b0, rd, er, lat);
        check("reset-in-wait RAM unchanged", rd, exp80);

        // Response backpressure with a second request already pending.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40;
        req_size = 2'b10; req_unsigned = 1'b0;
        @(negedge clk);
        req_addr = 32'h44;
        wait_resp(lat);
        check("bp first latency", lat, 32'd3);
        repeat (5) begin
            @(negedge clk);
            check("bp resp_valid held", {31'd0, resp_valid}, 32'd1);
            check("bp resp_rdata held", resp_rdata, 32'hDEADBEEF);
            check("bp req_ready low", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("bp after consume req_ready", {31'd0, req_ready}, 32'd1);
        check("bp after consume resp_valid", {31'd0, resp_valid}, 32'd0);
        check("bp after consume resp_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        wait_resp(lat);
        check("bp second latency", lat, 32'd3);
        check("bp second rdata", resp_rdata, 32'h1122A544);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Memory-side responder for the core's data port. It accepts one load/store request at a time over a valid/ready handshake and holds it for a programmable number of wait states. It then performs a sized, byte-lane access into internal word-organised RAM and returns a response over a second valid/ready handshake. The 5-stage pipeline uses it as a slow data memory so that stall and hazard logic gets exercised.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the RAM; must be a power of 2, at least 2.
WAIT_CYCLES, 2, wait states between request acceptance and the access; range 0..15.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_write  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
resp_valid  output  1  response present
resp_ready  input  1  requester accepts response
resp_rdata  output  32  load data, extended; 0 for stores
resp_err  output  1  access error (only driven when the optional feature is enabled)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset, sampled on the rising edge of clk.
- Reset values:
  - state = IDLE, so req_ready = 1 in the first cycle after reset.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0, wait counter = 0.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- req_ready:
  - req_ready = (state == IDLE), decoded directly from state with no combinational path from other inputs.
- IDLE:
  - On req_valid && req_ready, latch write, addr, wdata, size and unsigned.
  - If WAIT_CYCLES > 0: go to WAIT with counter = WAIT_CYCLES - 1.
  - If WAIT_CYCLES = 0: perform the access and go straight to RESP.
- WAIT:
  - If counter = 0, perform the access and go to RESP; otherwise decrement the counter.
- The access happens on the clock edge that enters RESP:
  - A store writes the RAM.
  - resp_rdata and resp_err are registered.
  - resp_valid goes to 1.
- Latency: resp_valid rises exactly WAIT_CYCLES+1 cycles after the handshake cycle.
- RESP:
  - resp_valid, resp_rdata and resp_err are held stable until resp_ready = 1.
  - On the edge with resp_ready = 1: resp_valid -> 0, resp_rdata and resp_err -> 0, state -> IDLE.
  - A new request can be accepted in the cycle after the response is consumed. There is no back-to-back overlap.
- Addressing:
  - Word index = req_addr[2+log2(DEPTH_WORDS)-1 : 2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Stores:
  - Byte: write lane addr[1:0] with wdata[7:0].
  - Half: write lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - Word: write all 4 lanes.
  - Lanes not written keep their value.
- Loads:
  - Byte: take the byte at addr[1:0].
  - Half: take the halfword at addr[1].
  - Sign- or zero-extend per the latched req_unsigned.
- Misalignment (macro absent): addr[0] is ignored for halfwords; addr[1:0] are ignored for words.
- Inputs are ignored in WAIT and RESP; in particular, req_valid is not latched.
- Reset mid-operation: if reset occurs in WAIT, the pending store is dropped (RAM unchanged). If reset occurs in RESP, the response is discarded.
- Read-after-write: a load following a store to the same address returns the stored data, since accesses are strictly serialized.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - Half with addr[0] = 1, or word with addr[1:0] != 0, is misaligned.
  - A misaligned store does not write the RAM.
  - A misaligned load returns resp_rdata = 0.
  - Either case returns resp_err = 1 with the same latency.
- Undefined: resp_err is tied to 0 and the misalignment rules in Behaviour apply.

Test Plan:
- Reset, then idle: req_ready = 1, resp_valid = 0 in the first cycle after reset is released.
- Word store then load, WAIT_CYCLES = 2:
  - Store 0xDEADBEEF to 0x40: resp_valid rises 3 cycles after the handshake, resp_rdata = 0.
  - Load 0x40: resp_rdata = 0xDEADBEEF.
- Byte store to 0x41 with wdata = 0x000000A5 over word 0x11223344:
  - Word load returns 0x1122A544.
  - Signed byte load at 0x41 returns 0xFFFFFFA5; unsigned returns 0x000000A5.
- Half load at 0x42 of word 0x8001_7FFF: signed returns 0xFFFF8001, unsigned returns 0x00008001.
- Response backpressure: hold resp_ready = 0 for 5 cycles. resp_valid and resp_rdata stay stable, req_ready = 0, and a second request is not accepted until the cycle after resp_ready = 1.
- Wrap and reset:
  - With DEPTH_WORDS = 256, a store to 0x400 aliases 0x000.
  - Asserting reset in WAIT during a store to 0x80 leaves RAM[0x80] unchanged, and resp_valid never rises.
  - With MISALIGN_TRAP_EN defined, a word store to 0x82 gives resp_err = 1 and memory is unchanged.
